sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 20 ++
 rtl/sram_arbiter_if.sv | 32 +++
 rtl/sram_pad_ctrl.sv | 106 ++++++++++
 rtl/sram_arbiter.sv | 124 ++++++++++++
 tb/tb_sram_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and default sizing for the SRAM arbiter slice.
// Provides the arbiter state encoding and a client-slot helper.
package sram_arb_pkg;

   localparam int ADDR_W_DEF     = 20;
   localparam int DATA_W_DEF     = 16;
   localparam int STARVE_MAX_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VGA_RD = 2'd1,
      ST_CLI_RD = 2'd2,
      ST_CLI_WR = 2'd3
   } arb_state_e;

   function automatic logic is_cli(input arb_state_e s);
      return (s == ST_CLI_RD) || (s == ST_CLI_WR);
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Scanout and client handshake bundle between requesters and the SRAM arbiter.
// The master side drives requests; the slave side is the arbiter.
interface sram_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              iVGA_REQ;
   logic [ADDR_W-1:0] iVGA_ADDR;
   logic [DATA_W-1:0] oVGA_DATA;
   logic              oVGA_VALID;
   logic              oVGA_MISS;
   logic              iCLI_REQ;
   logic              iCLI_WE;
   logic [ADDR_W-1:0] iCLI_ADDR;
   logic [DATA_W-1:0] iCLI_WDATA;
   logic              oCLI_GNT;
   logic [DATA_W-1:0] oCLI_RDATA;
   logic              oCLI_RVALID;

   modport master (
      output iVGA_REQ, iVGA_ADDR, iCLI_REQ, iCLI_WE, iCLI_ADDR, iCLI_WDATA,
      input  oVGA_DATA, oVGA_VALID, oVGA_MISS, oCLI_GNT, oCLI_RDATA, oCLI_RVALID
   );

   modport slave (
      input  iVGA_REQ, iVGA_ADDR, iCLI_REQ, iCLI_WE, iCLI_ADDR, iCLI_WDATA,
      output oVGA_DATA, oVGA_VALID, oVGA_MISS, oCLI_GNT, oCLI_RDATA, oCLI_RVALID
   );

endinterface

// File: rtl/sram_pad_ctrl.sv
// SRAM pin drivers: registered strobes, address, DQ tri-state and read capture.
// Pins follow the next arbiter state; read data is captured at the end of the access.
module sram_pad_ctrl
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  arb_state_e        state_d,
   input  arb_state_e        state_q,
   input  logic [ADDR_W-1:0] vga_addr,
   input  logic [ADDR_W-1:0] cli_addr,
   input  logic [DATA_W-1:0] cli_wdata,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_dq,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [DATA_W-1:0] vga_data,
   output logic [DATA_W-1:0] cli_data
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
   logic              dq_oe_q, dq_oe_d;
   logic [DATA_W-1:0] dq_out_q, dq_out_d;
   logic [DATA_W-1:0] vga_data_q, vga_data_d, cli_data_q, cli_data_d;

   always_comb begin
      addr_d   = addr_q;
      ce_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      we_n_d   = 1'b1;
      dq_oe_d  = 1'b0;
      dq_out_d = dq_out_q;
      case (state_d)
         ST_VGA_RD: begin
            addr_d = vga_addr;
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
         end
         ST_CLI_RD: begin
            addr_d = cli_addr;
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
         end
         ST_CLI_WR: begin
            addr_d   = cli_addr;
            ce_n_d   = 1'b0;
            we_n_d   = 1'b0;
            dq_oe_d  = 1'b1;
            dq_out_d = cli_wdata;
         end
         default: begin
            addr_d = addr_q;
         end
      endcase
   end

   // The bus is valid for the whole access cycle, so sample it as the access ends.
   always_comb begin
      if (state_q == ST_VGA_RD) begin
         vga_data_d = sram_dq;
      end else begin
         vga_data_d = vga_data_q;
      end
      if (state_q == ST_CLI_RD) begin
         cli_data_d = sram_dq;
      end else begin
         cli_data_d = cli_data_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         dq_oe_q    <= 1'b0;
         dq_out_q   <= '0;
         vga_data_q <= '0;
         cli_data_q <= '0;
      end else begin
         addr_q     <= addr_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         dq_oe_q    <= dq_oe_d;
         dq_out_q   <= dq_out_d;
         vga_data_q <= vga_data_d;
         cli_data_q <= cli_data_d;
      end
   end

   assign sram_dq   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
   assign sram_addr = addr_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign vga_data  = vga_data_q;
   assign cli_data  = cli_data_q;

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: scanout reads have priority over a client port.
// Define SRAM_ARBITER_STARVE_EN to let a starved client pre-empt one scanout read.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   sram_arbiter_if.slave     bus,
   output logic [ADDR_W-1:0] oSRAM_ADDR,
   inout  wire  [DATA_W-1:0] ioSRAM_DQ,
   output logic              oSRAM_CE_N,
   output logic              oSRAM_OE_N,
   output logic              oSRAM_WE_N
);

   arb_state_e state_q, state_d;
   logic       blocked_s, force_s;
   logic       gnt_q, gnt_d, vga_valid_q, vga_valid_d, cli_rvalid_q, cli_rvalid_d;

   // A client slot is never followed by another, so a held request is granted once.
   assign blocked_s = is_cli(state_q);

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      if (bus.iVGA_REQ && !force_s) begin
         state_d = ST_VGA_RD;
      end else if (bus.iCLI_REQ && !blocked_s) begin
         state_d = bus.iCLI_WE ? ST_CLI_WR : ST_CLI_RD;
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      gnt_d        = is_cli(state_d);
      vga_valid_d  = (state_q == ST_VGA_RD);
      cli_rvalid_d = (state_q == ST_CLI_RD);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         gnt_q        <= 1'b0;
         vga_valid_q  <= 1'b0;
         cli_rvalid_q <= 1'b0;
      end else begin
         gnt_q        <= gnt_d;
         vga_valid_q  <= vga_valid_d;
         cli_rvalid_q <= cli_rvalid_d;
      end
   end

`ifdef SRAM_ARBITER_STARVE_EN
   logic [7:0] starve_q, starve_d;
   logic       miss_pend_q, miss_pend_d, miss_q;

   assign force_s     = bus.iCLI_REQ && !blocked_s && (starve_q == 8'(STARVE_MAX));
   assign miss_pend_d = force_s && bus.iVGA_REQ;

   // Wait counter saturates rather than wrapping back below the threshold.
   always_comb begin
      starve_d = starve_q;
      if (!bus.iCLI_REQ) begin
         starve_d = starve_q;
      end else if (is_cli(state_d)) begin
         starve_d = 8'd0;
      end else if (starve_q != 8'hFF) begin
         starve_d = starve_q + 8'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         starve_q    <= 8'd0;
         miss_pend_q <= 1'b0;
         miss_q      <= 1'b0;
      end else begin
         starve_q    <= starve_d;
         miss_pend_q <= miss_pend_d;
         miss_q      <= miss_pend_q;
      end
   end

   assign bus.oVGA_MISS = miss_q;
`else
   assign force_s       = 1'b0;
   assign bus.oVGA_MISS = 1'b0;
`endif

   sram_pad_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pad (
      .clk       (iCLK),
      .rst_n     (iRST_N),
      .state_d   (state_d),
      .state_q   (state_q),
      .vga_addr  (bus.iVGA_ADDR),
      .cli_addr  (bus.iCLI_ADDR),
      .cli_wdata (bus.iCLI_WDATA),
      .sram_addr (oSRAM_ADDR),
      .sram_dq   (ioSRAM_DQ),
      .sram_ce_n (oSRAM_CE_N),
      .sram_oe_n (oSRAM_OE_N),
      .sram_we_n (oSRAM_WE_N),
      .vga_data  (bus.oVGA_DATA),
      .cli_data  (bus.oCLI_RDATA)
   );

   assign bus.oCLI_GNT    = gnt_q;
   assign bus.oVGA_VALID  = vga_valid_q;
   assign bus.oCLI_RVALID = cli_rvalid_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter with an async SRAM device and a slot-level model.
// The model schedules each slot from the priority rules and checks the pins every cycle.
module tb_sram_arbiter;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int SMAX = 4;
   localparam int K_IDLE = 0, K_VGA = 1, K_CRD = 2, K_CWR = 3;
`ifdef SRAM_ARBITER_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   wire  [DW-1:0] dq;
   logic [AW-1:0] sram_addr;
   logic          ce_n, oe_n, we_n;
   int            n_pass = 0, n_total = 0, n_vvalid = 0, n_miss = 0;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
      .iCLK(clk), .iRST_N(rst_n), .bus(bus), .oSRAM_ADDR(sram_addr),
      .ioSRAM_DQ(dq), .oSRAM_CE_N(ce_n), .oSRAM_OE_N(oe_n), .oSRAM_WE_N(we_n)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(input int a);
      logic [31:0] t;
      t = (32'(a) * 32'd40503) ^ 32'h00005A3C;
      return t[15:0];
   endfunction

   // Asynchronous SRAM device (4K words visible)
   logic [15:0] dev_mem [0:4095];
   bit          dev_wr  [0:4095];
   assign dq = (!ce_n && !oe_n && we_n) ?
               (dev_wr[sram_addr[11:0]] ? dev_mem[sram_addr[11:0]] : init_word(int'(sram_addr[11:0])))
               : 16'hzzzz;
   always @(posedge clk) begin
      if (!ce_n && !we_n) begin
         dev_mem[sram_addr[11:0]] <= dq;
         dev_wr[sram_addr[11:0]]  <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: one slot per cycle decided from the priority rules
   logic [15:0] m_mem [0:4095];
   int          m_kind, m_cnt;
   logic [19:0] m_addr;
   logic [15:0] m_wd, e_vdata, e_rdata;
   bit          m_miss_pend, e_vvalid, e_rvalid, e_miss;

   initial begin
      for (int i = 0; i < 4096; i++) m_mem[i] = init_word(i);
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_kind = K_IDLE; m_cnt = 0; m_addr = 20'd0; m_wd = 16'd0;
            m_miss_pend = 1'b0; e_vvalid = 1'b0; e_rvalid = 1'b0; e_miss = 1'b0;
            e_vdata = 16'd0; e_rdata = 16'd0;
         end else begin
            bit vreq, creq, blocked, forced;
            int nk;
            vreq = bus.iVGA_REQ; creq = bus.iCLI_REQ;
            e_miss = m_miss_pend; m_miss_pend = 1'b0;
            e_vvalid = 1'b0; e_rvalid = 1'b0;
            case (m_kind)
               K_VGA: begin e_vvalid = 1'b1; e_vdata = m_mem[m_addr[11:0]]; end
               K_CRD: begin e_rvalid = 1'b1; e_rdata = m_mem[m_addr[11:0]]; end
               K_CWR: m_mem[m_addr[11:0]] = m_wd;
               default: ;
            endcase
            blocked = (m_kind == K_CRD) || (m_kind == K_CWR);
            forced = STARVE_EN && creq && !blocked && (m_cnt == SMAX);
            if (vreq && !forced) nk = K_VGA;
            else if (creq && !blocked) nk = bus.iCLI_WE ? K_CWR : K_CRD;
            else nk = K_IDLE;
            if (forced && vreq) m_miss_pend = 1'b1;
            if (STARVE_EN && creq) begin
               if (nk == K_CRD || nk == K_CWR) m_cnt = 0;
               else if (m_cnt < 255) m_cnt++;
            end
            m_kind = nk;
            if (nk == K_VGA) m_addr = bus.iVGA_ADDR;
            else if (nk != K_IDLE) begin m_addr = bus.iCLI_ADDR; m_wd = bus.iCLI_WDATA; end
         end
      end
   end

   // Compare DUT pins against the model in mid-cycle
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("cli_gnt", bus.oCLI_GNT, (m_kind == K_CRD || m_kind == K_CWR));
         chk("ce_n", ce_n, (m_kind == K_IDLE));
         chk("oe_n", oe_n, !(m_kind == K_VGA || m_kind == K_CRD));
         chk("we_n", we_n, (m_kind != K_CWR));
         chk("dq_drive", dut.u_pad.dq_oe_q, (m_kind == K_CWR));
         if (m_kind == K_CWR) chk("dq_wdata", dq, m_wd);
         chk("sram_addr", sram_addr, m_addr);
         chk("vga_valid", bus.oVGA_VALID, e_vvalid);
         chk("vga_data", bus.oVGA_DATA, e_vdata);
         chk("cli_rvalid", bus.oCLI_RVALID, e_rvalid);
         chk("cli_rdata", bus.oCLI_RDATA, e_rdata);
         chk("vga_miss", bus.oVGA_MISS, e_miss);
         if (bus.oVGA_VALID) n_vvalid++;
         if (bus.oVGA_MISS) n_miss++;
      end
   end

   task automatic cli_op(input bit we, input logic [19:0] a, input logic [15:0] d,
                         output int waited, output int gnts, output logic rv,
                         output logic [15:0] rdv, output logic wen, output logic [15:0] dqv);
      bit got;
      @(posedge clk); #1;
      bus.iCLI_REQ = 1'b1; bus.iCLI_WE = we; bus.iCLI_ADDR = a; bus.iCLI_WDATA = d;
      waited = 0; gnts = 0; got = 1'b0; wen = 1'b1; dqv = 16'd0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk); waited++;
         if (bus.oCLI_GNT) begin got = 1'b1; wen = we_n; dqv = dq; end
      end
      if (!got) chk("gnt_timeout", 32'd0, 32'd1);
      else gnts = 1;
      @(posedge clk); #1;
      bus.iCLI_REQ = 1'b0;
      @(negedge clk);
      rv = bus.oCLI_RVALID; rdv = bus.oCLI_RDATA;
      if (bus.oCLI_GNT) gnts++;
      @(negedge clk);
      if (bus.oCLI_GNT) gnts++;
   endtask

   task automatic vga_run(input int n, input int pct);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.iVGA_REQ = ($urandom_range(99) < pct);
         bus.iVGA_ADDR = 20'($urandom_range(4095));
      end
      @(posedge clk); #1;
      bus.iVGA_REQ = 1'b0;
   endtask

   initial begin
      int w, g, v0, m0, pulses;
      logic rv, wen;
      logic [15:0] rd, dqv;
      bus.iVGA_REQ = 1'b0; bus.iVGA_ADDR = 20'd0; bus.iCLI_REQ = 1'b0;
      bus.iCLI_WE = 1'b0; bus.iCLI_ADDR = 20'd0; bus.iCLI_WDATA = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ce_n", ce_n, 1'b1);
      chk("rst_oe_n", oe_n, 1'b1);
      chk("rst_we_n", we_n, 1'b1);
      chk("rst_addr", sram_addr, 20'd0);
      chk("rst_dq_drive", dut.u_pad.dq_oe_q, 1'b0);
      chk("rst_strobes", {bus.oCLI_GNT, bus.oVGA_VALID, bus.oCLI_RVALID, bus.oVGA_MISS}, 4'd0);
      chk("rst_data", {bus.oVGA_DATA, bus.oCLI_RDATA}, 32'd0);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);

      cli_op(1'b1, 20'h00A05, 16'hFFFF, w, g, rv, rd, wen, dqv);
      chk("wr_gnt_latency", w, 2);
      chk("wr_gnt_once", g, 1);
      chk("wr_we_n_low", wen, 1'b0);
      chk("wr_dq_bus", dqv, 16'hFFFF);
      chk("wr_no_rvalid", rv, 1'b0);
      cli_op(1'b0, 20'h00A05, 16'h0000, w, g, rv, rd, wen, dqv);
      chk("rd_gnt_latency", w, 2);
      chk("rd_rvalid", rv, 1'b1);
      chk("rd_data", rd, 16'hFFFF);

      v0 = n_vvalid;
      vga_run(200, 100);
      repeat (3) @(negedge clk);
      chk("vga_valid_count", n_vvalid - v0, 200);

      fork
         begin
            @(posedge clk); #1;
            bus.iVGA_REQ = 1'b1; bus.iVGA_ADDR = 20'h00321;
            repeat (2) begin @(posedge clk); #1; bus.iVGA_ADDR = bus.iVGA_ADDR + 20'd1; end
            @(posedge clk); #1;
            bus.iVGA_REQ = 1'b0;
         end
         cli_op(1'b0, 20'h00A05, 16'h0000, w, g, rv, rd, wen, dqv);
      join
      chk("mix_gnt_latency", w, 5);
      chk("mix_gnt_once", g, 1);
      chk("mix_rd_data", rd, 16'hFFFF);

`ifdef SRAM_ARBITER_STARVE_EN
      m0 = n_miss;
      fork
         vga_run(12, 100);
         cli_op(1'b0, 20'h00123, 16'h0000, w, g, rv, rd, wen, dqv);
      join
      repeat (3) @(negedge clk);
      chk("starve_gnt_latency", w, 6);
      chk("starve_gnt_once", g, 1);
      chk("starve_miss_count", n_miss - m0, 1);
`endif

      fork
         vga_run(1500, 55);
         begin
            for (int k = 0; k < 60; k++) begin
               repeat ($urandom_range(8)) @(posedge clk);
               cli_op(1'($urandom_range(1)), 20'($urandom_range(63)), 16'($urandom),
                      w, g, rv, rd, wen, dqv);
               chk("rand_gnt_once", g, 1);
            end
         end
      join

      @(posedge clk); #1;
      bus.iCLI_REQ = 1'b1; bus.iCLI_WE = 1'b1; bus.iCLI_ADDR = 20'h000B0; bus.iCLI_WDATA = 16'h1234;
      w = 0;
      for (int i = 0; i < 50 && !bus.oCLI_GNT; i++) begin @(negedge clk); w++; end
      chk("abort_reached_write", we_n, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_we_n", we_n, 1'b1);
      chk("abort_dq_drive", dut.u_pad.dq_oe_q, 1'b0);
      chk("abort_ce_n", ce_n, 1'b1);
      bus.iCLI_REQ = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.oCLI_GNT || bus.oCLI_RVALID || bus.oVGA_VALID) pulses++;
      end
      chk("abort_no_strobes", pulses, 0);
      cli_op(1'b0, 20'h000B0, 16'h0000, w, g, rv, rd, wen, dqv);
      chk("abort_no_write", rd, init_word(176));

      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
